// File: rtl/branch_predictor_pkg.sv
// Shared encodings, FSM states and PC field helpers for the branch predictor family.
package branch_predictor_pkg;

    localparam int PC_MAX_W = 64;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam cnt_e CNT_INIT = WNT;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Word-aligned PCs: bits [1:0] never take part in index or tag.
    function automatic logic [PC_MAX_W-1:0] pc_index(input logic [PC_MAX_W-1:0] pc,
                                                     input int unsigned index_bits);
        logic [PC_MAX_W-1:0] mask;
        mask = (PC_MAX_W'(1) << index_bits) - PC_MAX_W'(1);
        return (pc >> 2) & mask;
    endfunction

    function automatic logic [PC_MAX_W-1:0] pc_tag(input logic [PC_MAX_W-1:0] pc,
                                                   input int unsigned index_bits);
        return pc >> (index_bits + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter_table.sv
// Direct-mapped table of 2-bit saturating counters with an init write port,
// a read-modify-write training port and an asynchronous read port.
module bp_sat_counter_table
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  init_en,
    input  logic [INDEX_BITS-1:0] init_idx,
    input  logic                  upd_en,
    input  logic [INDEX_BITS-1:0] upd_idx,
    input  logic                  upd_taken,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output cnt_e                  rd_cnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    cnt_e                  cnt_q [ENTRIES];
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    cnt_e                  wr_val;
    cnt_e                  upd_cur;

    function automatic cnt_e sat_inc(input cnt_e c);
        return (c == ST) ? ST : cnt_e'(c + 2'd1);
    endfunction

    function automatic cnt_e sat_dec(input cnt_e c);
        return (c == SNT) ? SNT : cnt_e'(c - 2'd1);
    endfunction

    assign upd_cur = cnt_q[upd_idx];
    assign rd_cnt  = cnt_q[rd_idx];

    // The init sweep owns the write port; training is ignored while it runs.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = upd_idx;
        wr_val = upd_taken ? sat_inc(upd_cur) : sat_dec(upd_cur);
        if (init_en) begin
            wr_en  = 1'b1;
            wr_idx = init_idx;
            wr_val = CNT_INIT;
        end else if (upd_en) begin
            wr_en  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            cnt_q[wr_idx] <= wr_val;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with BTB: zero-latency lookup for IF, training from EX,
// post-reset table sweep and saturating branch/mispredict performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int DBITS      = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_BITS   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DBITS-1:0]    IF_PC,
    output logic                prediction,
    output logic [DBITS-1:0]    predTarget,
    output logic                ready,
    input  logic                update,
    input  logic [DBITS-1:0]    EX_PC,
    input  logic [DBITS-1:0]    EX_PC_IMM,
    input  logic                EX_condFlag,
    input  logic                correct,
    output logic [CNT_BITS-1:0] branchCount,
    output logic [CNT_BITS-1:0] mispredCount
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = DBITS - INDEX_BITS - 2;

    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
    logic [CNT_BITS-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_BITS-1:0]   mispred_cnt_q, mispred_cnt_d;

    logic                  btb_valid_q [ENTRIES];
    logic [TAG_W-1:0]      btb_tag_q   [ENTRIES];
    logic [DBITS-1:0]      btb_tgt_q   [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]      if_tag, ex_tag;
    logic                  in_init, train, hit;
    cnt_e                  rd_cnt;

    logic                  btb_we;
    logic [INDEX_BITS-1:0] btb_widx;
    logic                  btb_wvalid;
    logic [TAG_W-1:0]      btb_wtag;
    logic [DBITS-1:0]      btb_wtgt;

    function automatic logic [CNT_BITS-1:0] sat_inc_cnt(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign if_idx  = INDEX_BITS'(pc_index(PC_MAX_W'(IF_PC), INDEX_BITS));
    assign if_tag  = TAG_W'(pc_tag(PC_MAX_W'(IF_PC), INDEX_BITS));
    assign ex_idx  = INDEX_BITS'(pc_index(PC_MAX_W'(EX_PC), INDEX_BITS));
    assign ex_tag  = TAG_W'(pc_tag(PC_MAX_W'(EX_PC), INDEX_BITS));

    assign in_init = (state_q == INIT);
    assign ready   = (state_q == RUN);
    assign train   = ready && update;

    bp_sat_counter_table #(
        .INDEX_BITS (INDEX_BITS)
    ) u_cnt_table (
        .clk       (clk),
        .init_en   (in_init),
        .init_idx  (init_idx_q),
        .upd_en    (train),
        .upd_idx   (ex_idx),
        .upd_taken (EX_condFlag),
        .rd_idx    (if_idx),
        .rd_cnt    (rd_cnt)
    );

    // Lookup reads pre-update state; a same-cycle training write shows up next cycle.
    assign hit        = ready && btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
    assign prediction = hit && ((rd_cnt == WT) || (rd_cnt == ST));
    assign predTarget = hit ? btb_tgt_q[if_idx] : '0;

    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        case (state_q)
            INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (update) begin
                    branch_cnt_d = sat_inc_cnt(branch_cnt_q);
                    if (!correct) begin
                        mispred_cnt_d = sat_inc_cnt(mispred_cnt_q);
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Sweep clears every BTB field so lookups never see uninitialised storage.
    always_comb begin
        btb_we     = 1'b0;
        btb_widx   = ex_idx;
        btb_wvalid = 1'b1;
        btb_wtag   = ex_tag;
        btb_wtgt   = EX_PC_IMM;
        if (in_init) begin
            btb_we     = 1'b1;
            btb_widx   = init_idx_q;
            btb_wvalid = 1'b0;
            btb_wtag   = '0;
            btb_wtgt   = '0;
        end else if (train && EX_condFlag) begin
            btb_we     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= INIT;
            init_idx_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_valid_q[btb_widx] <= btb_wvalid;
            btb_tag_q[btb_widx]   <= btb_wtag;
            btb_tgt_q[btb_widx]   <= btb_wtgt;
        end
    end

    assign branchCount  = branch_cnt_q;
    assign mispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: sweep timing, lookup/training vectors and perf counters.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_PC;
    logic        prediction, prediction2;
    logic [31:0] predTarget, predTarget2;
    logic        ready, ready2;
    logic        update, upd2;
    logic [31:0] EX_PC, EX_PC_IMM;
    logic        EX_condFlag, correct;
    logic [31:0] branchCount, mispredCount;
    logic [3:0]  branchCount2, mispredCount2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.DBITS(32), .INDEX_BITS(6), .CNT_BITS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .IF_PC        (IF_PC),
        .prediction   (prediction),
        .predTarget   (predTarget),
        .ready        (ready),
        .update       (update),
        .EX_PC        (EX_PC),
        .EX_PC_IMM    (EX_PC_IMM),
        .EX_condFlag  (EX_condFlag),
        .correct      (correct),
        .branchCount  (branchCount),
        .mispredCount (mispredCount)
    );

    branch_predictor #(.DBITS(32), .INDEX_BITS(2), .CNT_BITS(4)) dut_small (
        .clk          (clk),
        .reset        (reset),
        .IF_PC        (IF_PC),
        .prediction   (prediction2),
        .predTarget   (predTarget2),
        .ready        (ready2),
        .update       (upd2),
        .EX_PC        (EX_PC),
        .EX_PC_IMM    (EX_PC_IMM),
        .EX_condFlag  (EX_condFlag),
        .correct      (correct),
        .branchCount  (branchCount2),
        .mispredCount (mispredCount2)
    );

    typedef struct {
        logic        upd;
        logic [31:0] ex_pc;
        logic [31:0] imm;
        logic        cond;
        logic [31:0] if_pc;
        logic        exp_pred;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is at the negedge of the first cycle after reset release.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < 64; i++) begin
            IF_PC       = 32'h40 + 32'(i * 4);
            EX_PC       = 32'h40;
            EX_PC_IMM   = 32'h100;
            EX_condFlag = 1'b1;
            correct     = 1'b0;
            update      = 1'b1;
            #1;
            check($sformatf("%s ready c%0d", tag, i + 1), 32'(ready), 32'd0);
            check($sformatf("%s pred c%0d", tag, i + 1), 32'(prediction), 32'd0);
            @(negedge clk);
        end
        update = 1'b0;
        IF_PC  = 32'h40;
        #1;
        check({tag, " ready c65"}, 32'(ready), 32'd1);
        check({tag, " pred after sweep"}, 32'(prediction), 32'd0);
        check({tag, " tgt after sweep"}, predTarget, 32'd0);
        check({tag, " branchCount dropped"}, branchCount, 32'd0);
        check({tag, " mispredCount dropped"}, mispredCount, 32'd0);
    endtask

    initial begin
        int exp_branch;

        vecs[0]  = '{1'b1, 32'h40,   32'h100, 1'b1, 32'h40,   1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0,    32'h0,   1'b0, 32'h40,   1'b1, 32'h100};
        vecs[2]  = '{1'b0, 32'h0,    32'h0,   1'b0, 32'h1040, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0,    32'h0,   1'b0, 32'h42,   1'b1, 32'h100};
        vecs[4]  = '{1'b1, 32'h40,   32'h100, 1'b1, 32'h40,   1'b1, 32'h100};
        vecs[5]  = '{1'b1, 32'h40,   32'h100, 1'b1, 32'h40,   1'b1, 32'h100};
        vecs[6]  = '{1'b1, 32'h40,   32'h100, 1'b0, 32'h40,   1'b1, 32'h100};
        vecs[7]  = '{1'b1, 32'h40,   32'h100, 1'b0, 32'h40,   1'b1, 32'h100};
        vecs[8]  = '{1'b0, 32'h0,    32'h0,   1'b0, 32'h40,   1'b0, 32'h100};
        vecs[9]  = '{1'b1, 32'h1040, 32'h999, 1'b0, 32'h40,   1'b0, 32'h100};
        vecs[10] = '{1'b1, 32'h1040, 32'h200, 1'b1, 32'h40,   1'b0, 32'h100};
        vecs[11] = '{1'b0, 32'h0,    32'h0,   1'b0, 32'h1040, 1'b0, 32'h200};
        vecs[12] = '{1'b0, 32'h0,    32'h0,   1'b0, 32'h40,   1'b0, 32'h0};
        vecs[13] = '{1'b1, 32'h1040, 32'h200, 1'b1, 32'h1040, 1'b0, 32'h200};
        vecs[14] = '{1'b0, 32'h0,    32'h0,   1'b0, 32'h1040, 1'b1, 32'h200};
        vecs[15] = '{1'b1, 32'h80,   32'hABC, 1'b1, 32'h80,   1'b0, 32'h0};
        vecs[16] = '{1'b0, 32'h0,    32'h0,   1'b0, 32'h80,   1'b1, 32'hABC};
        vecs[17] = '{1'b0, 32'h0,    32'h0,   1'b0, 32'h1040, 1'b1, 32'h200};

        reset = 1'b1; update = 1'b0; upd2 = 1'b0; IF_PC = '0;
        EX_PC = '0; EX_PC_IMM = '0; EX_condFlag = 1'b0; correct = 1'b1;
        repeat (3) @(negedge clk);
        check("reset ready", 32'(ready), 32'd0);
        check("reset branchCount", branchCount, 32'd0);
        check("reset mispredCount", mispredCount, 32'd0);
        check("reset pred", 32'(prediction), 32'd0);
        reset = 1'b0;
        sweep_check("sweep1");

        exp_branch = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            update      = vecs[i].upd;
            EX_PC       = vecs[i].ex_pc;
            EX_PC_IMM   = vecs[i].imm;
            EX_condFlag = vecs[i].cond;
            correct     = 1'b1;
            IF_PC       = vecs[i].if_pc;
            #1;
            check($sformatf("vec%0d pred", i), 32'(prediction), 32'(vecs[i].exp_pred));
            check($sformatf("vec%0d tgt", i), predTarget, vecs[i].exp_tgt);
            check($sformatf("vec%0d branchCount", i), branchCount, 32'(exp_branch));
            check($sformatf("vec%0d mispredCount", i), mispredCount, 32'd0);
            if (vecs[i].upd) exp_branch++;
        end
        @(negedge clk);
        update = 1'b0;
        #1;
        check("table branchCount", branchCount, 32'(exp_branch));

        // Reset clears counters, then a reset pulse lands mid-sweep.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset2 ready", 32'(ready), 32'd0);
        check("reset2 branchCount", branchCount, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("midsweep ready", 32'(ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sweep_check("sweep2");
        check("sweep2 small ready", 32'(ready2), 32'd1);

        // Perf counters: 10 updates with 3 mispredicts, then 20 mispredicts.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            update      = 1'b1;
            upd2        = 1'b1;
            EX_PC       = 32'h200 + 32'(i * 4);
            EX_PC_IMM   = 32'h300;
            EX_condFlag = i[0];
            correct     = (i >= 10) ? 1'b0 : ((i % 3) != 2);
            if (i == 10) begin
                #1;
                check("perf10 branchCount", branchCount, 32'd10);
                check("perf10 mispredCount", mispredCount, 32'd3);
                check("perf10 small branchCount", 32'(branchCount2), 32'd10);
                check("perf10 small mispredCount", 32'(mispredCount2), 32'd3);
            end
        end
        @(negedge clk);
        update = 1'b0;
        upd2   = 1'b0;
        #1;
        check("perf30 branchCount", branchCount, 32'd30);
        check("perf30 mispredCount", mispredCount, 32'd23);
        check("perf30 small branchCount sat", 32'(branchCount2), 32'd15);
        check("perf30 small mispredCount sat", 32'(mispredCount2), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
